// File: rtl/rtc_pkg.sv
// Shared constants for the RTC bus responder: register map, FSM encoding
// and the BCD single-step helper used by the time-of-day chain.
package rtc_pkg;

  localparam logic [7:0] ADDR_SEC  = 8'h21;
  localparam logic [7:0] ADDR_MIN  = 8'h22;
  localparam logic [7:0] ADDR_HR   = 8'h23;
  localparam logic [7:0] ADDR_DAY  = 8'h24;
  localparam logic [7:0] ADDR_MON  = 8'h25;
  localparam logic [7:0] ADDR_YEAR = 8'h26;
  localparam logic [7:0] ADDR_TMR0 = 8'h41;
  localparam logic [7:0] ADDR_TMR1 = 8'h42;
  localparam logic [7:0] ADDR_TMR2 = 8'h43;
  localparam logic [7:0] ADDR_CMD0 = 8'hF0;
  localparam logic [7:0] ADDR_SNAP = 8'hF1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ADDR_WR = 2'd1;
  localparam logic [1:0] ST_DATA_WR = 2'd2;
  localparam logic [1:0] ST_DATA_RD = 2'd3;

  // One BCD step without the range wrap; a low nibble of 9 or more
  // (including non-BCD values) rolls into the high nibble.
  function automatic logic [7:0] bcd_step(input logic [7:0] v);
    if (v[3:0] >= 4'd9) bcd_step = {v[7:4] + 4'd1, 4'd0};
    else                bcd_step = v + 8'd1;
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Prescaler plus sec/min/hr BCD chain with host load ports and a snapshot
// shadow. A load always wins over a coincident tick and restarts the
// prescaler, so the written value holds for a full tick period.
module bcd_time_counter
  import rtc_pkg::*;
#(
  parameter int unsigned TICK_CICLOS = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_sec,
  input  logic       ld_min,
  input  logic       ld_hr,
  input  logic [7:0] ld_val,
  input  logic       snap,
  output logic [7:0] shadow_sec,
  output logic [7:0] shadow_min,
  output logic [7:0] shadow_hr
);

  localparam int unsigned PW = (TICK_CICLOS > 1) ? $clog2(TICK_CICLOS) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_CICLOS - 1);

  logic [PW-1:0] presc;
  logic [7:0]    sec_r, min_r, hr_r;
  logic          tick, sec_wrap, min_wrap;

  // Down-counter reaching terminal count marks the one-second tick.
  always_comb begin
    tick     = (presc == '0);
    sec_wrap = (sec_r >= 8'h59);
    min_wrap = (min_r >= 8'h59);
  end

  // Prescaler and BCD chain; loads pre-empt the tick and reload the prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= PRESC_TOP;
      sec_r <= 8'h00;
      min_r <= 8'h00;
      hr_r  <= 8'h00;
    end else if (ld_sec || ld_min || ld_hr) begin
      presc <= PRESC_TOP;
      if (ld_sec) sec_r <= ld_val;
      if (ld_min) min_r <= ld_val;
      if (ld_hr)  hr_r  <= ld_val;
    end else if (tick) begin
      presc <= PRESC_TOP;
      sec_r <= sec_wrap ? 8'h00 : bcd_step(sec_r);
      if (sec_wrap) min_r <= min_wrap ? 8'h00 : bcd_step(min_r);
      if (sec_wrap && min_wrap) hr_r <= (hr_r >= 8'h23) ? 8'h00 : bcd_step(hr_r);
    end else begin
      presc <= presc - PW'(1);
    end
  end

  // Shadow captures the registered (pre-increment) time on a snapshot command.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_sec <= 8'h00;
      shadow_min <= 8'h00;
      shadow_hr  <= 8'h00;
    end else if (snap) begin
      shadow_sec <= sec_r;
      shadow_min <= min_r;
      shadow_hr  <= hr_r;
    end
  end

endmodule

// File: rtl/rtc_bus_responder.sv
// Device-side emulation of the RTC multiplexed address/data bus: strobe
// sampling, cycle decode FSM, register file and read-data driver.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | no cycle in progress, waiting for cs with wr or rd low
//  ST_ADDR_WR | address phase write; latches address on wr_q rise
//  ST_DATA_WR | data phase write; commits to the register file on wr_q rise
//  ST_DATA_RD | data phase read; drives dato_out with dato_oe high
module rtc_bus_responder
  import rtc_pkg::*;
#(
  parameter int unsigned TICK_CICLOS = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_d,
  input  logic       cs,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] dato_in,
  output logic [7:0] dato_out,
  output logic       dato_oe,
  output logic [7:0] addr_actual,
  output logic       error_bus
);

  logic       a_d_q, a_d_qq, cs_q, wr_q, rd_q;
  logic [7:0] data_lat;
  logic [1:0] state;
  logic [7:0] day_r, mon_r, year_r, tmr0_r, tmr1_r, tmr2_r;
  logic [7:0] shadow_sec, shadow_min, shadow_hr;
  logic [7:0] rd_mux;
  logic       proto_err, addr_commit, data_commit, snap;

  // Single sample stage on the bus pins; a_d gets a second stage for change detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_d_q  <= 1'b1;
      a_d_qq <= 1'b1;
      cs_q   <= 1'b1;
      wr_q   <= 1'b1;
      rd_q   <= 1'b1;
    end else begin
      a_d_q  <= a_d;
      a_d_qq <= a_d_q;
      cs_q   <= cs;
      wr_q   <= wr;
      rd_q   <= rd;
    end
  end

  // Holds the bus value seen while wr_q was low, i.e. the value to commit.
  always_ff @(posedge clk) begin
    if (reset)      data_lat <= 8'h00;
    else if (!wr_q) data_lat <= dato_in;
  end

  // Error detection and commit qualification; an error cancels any commit.
  always_comb begin
    proto_err   = (!cs_q && !wr_q && !rd_q) ||
                  ((a_d_q != a_d_qq) && (!wr_q || !rd_q));
    addr_commit = (state == ST_ADDR_WR) && wr_q && !proto_err;
    data_commit = (state == ST_DATA_WR) && wr_q && !proto_err;
    snap        = addr_commit && (data_lat == ADDR_SNAP);
  end

  // Cycle decode FSM with registered read-data outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      dato_oe     <= 1'b0;
      dato_out    <= 8'h00;
      addr_actual <= 8'h00;
      error_bus   <= 1'b0;
    end else if (proto_err) begin
      state     <= ST_IDLE;
      dato_oe   <= 1'b0;
      dato_out  <= 8'h00;
      error_bus <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!cs_q && !wr_q) begin
            state <= a_d_q ? ST_DATA_WR : ST_ADDR_WR;
          end else if (!cs_q && !rd_q && a_d_q) begin
            state    <= ST_DATA_RD;
            dato_oe  <= 1'b1;
            dato_out <= rd_mux;
          end
        end
        ST_ADDR_WR: begin
          if (wr_q) begin
            addr_actual <= data_lat;
            state       <= ST_IDLE;
          end else if (cs_q) begin
            state <= ST_IDLE;
          end
        end
        ST_DATA_WR: begin
          if (wr_q || cs_q) state <= ST_IDLE;
        end
        ST_DATA_RD: begin
          if (rd_q || cs_q) begin
            state    <= ST_IDLE;
            dato_oe  <= 1'b0;
            dato_out <= 8'h00;
          end else begin
            dato_out <= rd_mux;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Plain storage registers; time registers are written through the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      day_r  <= 8'h00;
      mon_r  <= 8'h00;
      year_r <= 8'h00;
      tmr0_r <= 8'h00;
      tmr1_r <= 8'h00;
      tmr2_r <= 8'h00;
    end else if (data_commit) begin
      case (addr_actual)
        ADDR_DAY:  day_r  <= data_lat;
        ADDR_MON:  mon_r  <= data_lat;
        ADDR_YEAR: year_r <= data_lat;
        ADDR_TMR0: tmr0_r <= data_lat;
        ADDR_TMR1: tmr1_r <= data_lat;
        ADDR_TMR2: tmr2_r <= data_lat;
        default: ;
      endcase
    end
  end

  // Read mux; time reads come from the snapshot shadow, never the live chain.
  always_comb begin
    rd_mux = 8'h00;
    case (addr_actual)
      ADDR_SEC:             rd_mux = shadow_sec;
      ADDR_MIN:             rd_mux = shadow_min;
      ADDR_HR:              rd_mux = shadow_hr;
      ADDR_DAY:             rd_mux = day_r;
      ADDR_MON:             rd_mux = mon_r;
      ADDR_YEAR:            rd_mux = year_r;
      ADDR_TMR0:            rd_mux = tmr0_r;
      ADDR_TMR1:            rd_mux = tmr1_r;
      ADDR_TMR2:            rd_mux = tmr2_r;
      ADDR_CMD0, ADDR_SNAP: rd_mux = 8'h00;
      default:              rd_mux = 8'h00;
    endcase
  end

  bcd_time_counter #(.TICK_CICLOS(TICK_CICLOS)) u_time (
    .clk        (clk),
    .reset      (reset),
    .ld_sec     (data_commit && (addr_actual == ADDR_SEC)),
    .ld_min     (data_commit && (addr_actual == ADDR_MIN)),
    .ld_hr      (data_commit && (addr_actual == ADDR_HR)),
    .ld_val     (data_lat),
    .snap       (snap),
    .shadow_sec (shadow_sec),
    .shadow_min (shadow_min),
    .shadow_hr  (shadow_hr)
  );

endmodule
